muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide engine for the EX stage. Successor to the fixed multicyc unit.
- Executes MULT/MULTU/DIV/DIVU and MADD/MADDU/MSUB/MSUBU with configurable multiply latency and divide radix.
- Uses a valid/ready request handshake and returns a 64-bit {HI,LO} result, which EX writes to hilo.
- Supports abort on pipeline flush.

Parameters:
- DATA_WIDTH, 32, operand width (HI and LO are each DATA_WIDTH).
- MUL_CYCLES, 2, multiply pipeline depth in cycles (>=1).
- DIV_BITS, 1, quotient bits resolved per cycle (1 or 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  engine accepts request this cycle
- req_op  in  3  op: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- req_reg0  in  DATA_WIDTH  rs operand / dividend
- req_reg1  in  DATA_WIDTH  rt operand / divisor
- req_hilo  in  2*DATA_WIDTH  current {HI,LO}, sampled at accept (accumulate ops only)
- flush  in  1  abort in-flight op
- resp_valid  out  1  one-cycle pulse, result ready
- resp_hilo  out  2*DATA_WIDTH  {HI,LO} result, held until next accept
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_hilo=0; busy=0; all internal counters 0.
- Accept: req_valid & req_ready & ~flush. Operands, op and req_hilo are registered at accept. Inputs are ignored at all other times.
- req_ready = (state==IDLE). No back-to-back accept in the cycle resp_valid is asserted, so throughput is 1 op per latency+1 cycles.
- FSM states: IDLE, MUL, ACC, DPREP, DIV, DFIX, DONE.
  - IDLE -> MUL on a mul/madd/msub op; IDLE -> DPREP on a div op.
  - MUL: counter runs 0..MUL_CYCLES-1. Then -> DONE for MULT/MULTU, -> ACC for accumulate ops.
  - ACC: one cycle, 64-bit add/sub with req_hilo (wraps mod 2^64) -> DONE.
  - DPREP: take absolute values for signed ops; load remainder=0, quotient=|dividend|; -> DIV.
  - DIV: restoring division, DIV_BITS quotient bits per cycle, for DATA_WIDTH/DIV_BITS cycles -> DFIX.
  - DFIX: apply signs -> DONE.
  - DONE: resp_valid=1 for exactly this cycle, resp_hilo updated on entry -> IDLE.
- Latency (accept cycle to resp_valid cycle), with DATA_WIDTH=32:
  - MULT/MULTU: MUL_CYCLES+1.
  - MADD family: MUL_CYCLES+2.
  - DIV with DIV_BITS=1: 35. With DIV_BITS=2: 19.
- Signedness:
  - Signed multiply: full 64-bit two's-complement product. Unsigned ops zero-extend.
  - MSUB: resp = req_hilo - product.
  - Signed divide: LO = quotient, sign = sign(reg0)^sign(reg1); HI = remainder, sign = sign(reg0).
  - Signed divide 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap, no exception).
- Divide by zero: deterministic, same latency. LO=all ones, HI=dividend (raw reg0), signed and unsigned alike.
- Flush:
  - In any non-IDLE state, next state is IDLE; no resp_valid; resp_hilo retains its previous value.
  - flush with req_valid in IDLE drops the request.
  - flush in the DONE cycle does not suppress that resp_valid (result already committed).
- rst mid-operation: immediate return to reset values next cycle; no response.
- busy = ~req_ready.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - DPREP computes lz = leading-zero count of |dividend|, rounded down to a multiple of DIV_BITS.
  - Pre-shifts the quotient register by lz and skips those iterations.
  - DIV cycles become (DATA_WIDTH-lz)/DIV_BITS, minimum 1.
  - Dividend 0 takes 1 DIV cycle.
  - Results are bit-identical to the non-early-out build.
- Undefined: fixed divide latency as above.

Test Plan:
- MULT reg0=0xFFFFFFFE (-2), reg1=0x00000003, MUL_CYCLES=2 -> resp_valid at cycle 3 after accept, resp_hilo=0xFFFFFFFF_FFFFFFFA.
- MADDU reg0=0xFFFFFFFF, reg1=0x00000002, req_hilo=0x00000000_00000001 -> resp_hilo=0x00000001_FFFFFFFF at cycle 4.
- DIV reg0=0xFFFFFFF9 (-7), reg1=0x00000002, DIV_BITS=1 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, resp_valid at cycle 35; repeat with DIV_BITS=2 -> cycle 19.
- DIVU reg0=0x12345678, reg1=0 -> LO=0xFFFFFFFF, HI=0x12345678; then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIVU, assert flush at cycle 10 -> no resp_valid; req_ready=1 next cycle; resp_hilo unchanged; a following MULTU 3*5 returns 0x00000000_0000000F.
- MULTU with req_valid & flush in the same IDLE cycle -> not accepted, busy stays 0. With MULDIV_EARLY_OUT_EN, DIVU 0x00000010/0x3 -> LO=5, HI=1, in 5+2+1=8 cycles (DIV_BITS=1).

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU/MADD(U)/MSUB(U) engine returning {HI,LO}.
// Define MULDIV_EARLY_OUT_EN to skip leading-zero divide iterations.
module muldiv_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [DATA_WIDTH-1:0]   req_reg0,
  input  logic [DATA_WIDTH-1:0]   req_reg1,
  input  logic [2*DATA_WIDTH-1:0] req_hilo,
  input  logic                    flush,
  output logic                    resp_valid,
  output logic [2*DATA_WIDTH-1:0] resp_hilo,
  output logic                    busy
);
  localparam int W   = DATA_WIDTH;
  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int DCW = $clog2(W + 1);
  localparam logic [MCW-1:0] MUL_LAST  = MCW'(MUL_CYCLES - 1);
  localparam logic [DCW-1:0] DIV_ITERS = DCW'(W / DIV_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_ACC   = 3'd2,
    S_DPREP = 3'd3,
    S_DIV   = 3'd4,
    S_DFIX  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state_r, state_s, next_s;
  logic [2:0]       op_r;
  logic [W-1:0]     a_r, b_r, rem_r, quo_r, dvs_r;
  logic [2*W-1:0]   hilo_r, prod_r;
  logic [MCW-1:0]   mul_cnt_r;
  logic [DCW-1:0]   div_cnt_r;
  logic             neg_q_r, neg_r_r;

  logic             accept_s, is_signed_s;
  logic [2*W-1:0]   a_ext_s, b_ext_s, prod_s, result_s;
  logic [W-1:0]     abs_a_s, abs_b_s, quo_init_s, rem_step_s, quo_step_s, q_fix_s, r_fix_s;
  logic [W:0]       trial_s;
  logic [DCW-1:0]   iters_s;

  assign req_ready   = (state_r == S_IDLE);
  assign busy        = ~req_ready;
  assign resp_valid  = (state_r == S_DONE);
  assign accept_s    = req_valid & req_ready & ~flush;
  assign is_signed_s = ~op_r[0];

  assign a_ext_s = is_signed_s ? {{W{a_r[W-1]}}, a_r} : {{W{1'b0}}, a_r};
  assign b_ext_s = is_signed_s ? {{W{b_r[W-1]}}, b_r} : {{W{1'b0}}, b_r};
  assign prod_s  = a_ext_s * b_ext_s;

  assign abs_a_s = (is_signed_s && a_r[W-1]) ? -a_r : a_r;
  assign abs_b_s = (is_signed_s && b_r[W-1]) ? -b_r : b_r;
  assign q_fix_s = neg_q_r ? -quo_r : quo_r;
  assign r_fix_s = neg_r_r ? -rem_r : rem_r;

`ifdef MULDIV_EARLY_OUT_EN
  logic [DCW-1:0] lz_s;

  function automatic logic [DCW-1:0] lead_zeros(input logic [W-1:0] v);
    logic [DCW-1:0] n;
    logic           found;
    n     = {DCW{1'b0}};
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && !v[i]) begin
        n = n + DCW'(1);
      end else begin
        found = 1'b1;
      end
    end
    return n;
  endfunction
`endif

  // Divide setup: quotient seed and iteration count
  always_comb begin
    quo_init_s = abs_a_s;
    iters_s    = DIV_ITERS;
`ifdef MULDIV_EARLY_OUT_EN
    // Leading zero digits contribute zero quotient and leave the remainder at zero
    lz_s       = DCW'((int'(lead_zeros(abs_a_s)) / DIV_BITS) * DIV_BITS);
    quo_init_s = abs_a_s << lz_s;
    if (lz_s >= DCW'(W)) begin
      iters_s = DCW'(1);
    end else begin
      iters_s = DCW'((W - int'(lz_s)) / DIV_BITS);
    end
`endif
  end

  // One restoring-division step per quotient bit, DIV_BITS bits per cycle
  always_comb begin
    rem_step_s = rem_r;
    quo_step_s = quo_r;
    trial_s    = {(W+1){1'b0}};
    for (int i = 0; i < DIV_BITS; i++) begin
      trial_s    = {rem_step_s, quo_step_s[W-1]};
      quo_step_s = {quo_step_s[W-2:0], 1'b0};
      if (trial_s >= {1'b0, dvs_r}) begin
        trial_s       = trial_s - {1'b0, dvs_r};
        quo_step_s[0] = 1'b1;
      end else begin
        quo_step_s[0] = 1'b0;
      end
      rem_step_s = trial_s[W-1:0];
    end
  end

  // Value committed to resp_hilo on entry to DONE
  always_comb begin
    result_s = resp_hilo;
    case (state_r)
      S_MUL:   result_s = prod_s;
      S_ACC:   result_s = op_r[1] ? (hilo_r - prod_r) : (hilo_r + prod_r);
      S_DFIX: begin
        if (dvs_r == {W{1'b0}}) begin
          result_s = {a_r, {W{1'b1}}};
        end else begin
          result_s = {r_fix_s, q_fix_s};
        end
      end
      default: result_s = resp_hilo;
    endcase
  end

  // Next-state logic; flush aborts any in-flight operation
  always_comb begin
    next_s  = state_r;
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          next_s = (req_op[2:1] == 2'b01) ? S_DPREP : S_MUL;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_cnt_r == MUL_LAST) begin
          next_s = op_r[2] ? S_ACC : S_DONE;
        end else begin
          next_s = S_MUL;
        end
      end
      S_ACC:   next_s = S_DONE;
      S_DPREP: next_s = S_DIV;
      S_DIV: begin
        if (div_cnt_r == DCW'(1)) begin
          next_s = S_DFIX;
        end else begin
          next_s = S_DIV;
        end
      end
      S_DFIX:  next_s = S_DONE;
      S_DONE:  next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
    state_s = (flush && (state_r != S_IDLE)) ? S_IDLE : next_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= 3'd0;
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      hilo_r    <= {(2*W){1'b0}};
      prod_r    <= {(2*W){1'b0}};
      mul_cnt_r <= {MCW{1'b0}};
      div_cnt_r <= {DCW{1'b0}};
      rem_r     <= {W{1'b0}};
      quo_r     <= {W{1'b0}};
      dvs_r     <= {W{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      resp_hilo <= {(2*W){1'b0}};
    end else begin
      if (accept_s) begin
        op_r      <= req_op;
        a_r       <= req_reg0;
        b_r       <= req_reg1;
        hilo_r    <= req_hilo;
        mul_cnt_r <= {MCW{1'b0}};
        neg_q_r   <= ~req_op[0] & (req_reg0[W-1] ^ req_reg1[W-1]);
        neg_r_r   <= ~req_op[0] & req_reg0[W-1];
      end
      case (state_r)
        S_MUL: begin
          mul_cnt_r <= mul_cnt_r + MCW'(1);
          prod_r    <= prod_s;
        end
        S_DPREP: begin
          rem_r     <= {W{1'b0}};
          quo_r     <= quo_init_s;
          dvs_r     <= abs_b_s;
          div_cnt_r <= iters_s;
        end
        S_DIV: begin
          rem_r     <= rem_step_s;
          quo_r     <= quo_step_s;
          div_cnt_r <= div_cnt_r - DCW'(1);
        end
        default: begin
        end
      endcase
      if (state_s == S_DONE) begin
        resp_hilo <= result_s;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized bench for muldiv_iter: two instances (radix-2 and radix-4 divide,
// different multiply depths) checked against an arithmetic reference model.
module tb_muldiv_iter;
  localparam int MC1 = 2;
  localparam int DB1 = 1;
  localparam int MC2 = 3;
  localparam int DB2 = 2;

  logic        clk, rst, req_valid, flush;
  logic [2:0]  req_op;
  logic [31:0] req_reg0, req_reg1;
  logic [63:0] req_hilo;
  logic        rdy1, rv1, busy1, rdy2, rv2, busy2;
  logic [63:0] rh1, rh2;
  logic [63:0] last1, last2;

  int vectors = 0;
  int miscompares = 0;

  muldiv_iter #(.DATA_WIDTH(32), .MUL_CYCLES(MC1), .DIV_BITS(DB1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_op(req_op),
    .req_reg0(req_reg0), .req_reg1(req_reg1), .req_hilo(req_hilo), .flush(flush),
    .resp_valid(rv1), .resp_hilo(rh1), .busy(busy1));

  muldiv_iter #(.DATA_WIDTH(32), .MUL_CYCLES(MC2), .DIV_BITS(DB2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_op(req_op),
    .req_reg0(req_reg0), .req_reg1(req_reg1), .req_hilo(req_hilo), .flush(flush),
    .resp_valid(rv2), .resp_hilo(rh2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] h);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
    sb = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
    if (!op[2] && op[1]) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    p = sa * sb;
    if (!op[2]) return p;
    return op[1] ? (h - p) : (h + p);
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input int mc, input int db);
    int iters;
    int lz;
    logic [31:0] ab;
    iters = 32 / db;
    lz = 0;
    ab = (!op[0] && a[31]) ? -a : a;
`ifdef MULDIV_EARLY_OUT_EN
    while (lz < 32 && ab[31 - lz] == 1'b0) lz++;
    lz = (lz / db) * db;
    iters = (32 - lz) / db;
    if (iters < 1) iters = 1;
`endif
    if (!op[2] && op[1]) return iters + 3;
    return op[2] ? mc + 2 : mc + 1;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h);
    req_valid = 1'b1; req_op = op; req_reg0 = a; req_reg1 = b; req_hilo = h;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_reg0 = $urandom; req_reg1 = $urandom;
    req_hilo = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h);
    logic [63:0] e;
    int l1, l2;
    bit g1, g2;
    e = ref_model(op, a, b, h);
    l1 = exp_lat(op, a, MC1, DB1);
    l2 = exp_lat(op, a, MC2, DB2);
    g1 = 1'b0; g2 = 1'b0;
    issue(op, a, b, h);
    check_eq("busy", 64'({busy1, busy2}), 64'(2'b11));
    for (int n = 1; n <= 60 && !(g1 && g2); n++) begin
      if (rv1 && !g1) begin
        g1 = 1'b1;
        check_eq("lat1", 64'(n), 64'(l1));
        check_eq("res1", rh1, e);
      end
      if (rv2 && !g2) begin
        g2 = 1'b1;
        check_eq("lat2", 64'(n), 64'(l2));
        check_eq("res2", rh2, e);
      end
      @(posedge clk); #1;
    end
    check_eq("done", 64'({g1, g2}), 64'(2'b11));
    check_eq("pulse", 64'({rv1, rv2}), 64'(2'b00));
    check_eq("ready", 64'({rdy1, rdy2}), 64'(2'b11));
    check_eq("hold1", rh1, e);
    check_eq("hold2", rh2, e);
    last1 = e; last2 = e;
  endtask

  task automatic run_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] h, input int fc);
    logic [63:0] e;
    bit x1, x2;
    int c1, c2;
    e = ref_model(op, a, b, h);
    x1 = (fc >= exp_lat(op, a, MC1, DB1));
    x2 = (fc >= exp_lat(op, a, MC2, DB2));
    c1 = 0; c2 = 0;
    issue(op, a, b, h);
    for (int n = 1; n <= 60; n++) begin
      flush = (n == fc);
      if (n == fc + 1) check_eq("fl_ready", 64'({rdy1, rdy2}), 64'(2'b11));
      if (rv1) c1++;
      if (rv2) c2++;
      @(posedge clk); #1;
    end
    flush = 1'b0;
    check_eq("fl_resp1", 64'(c1), 64'(x1));
    check_eq("fl_resp2", 64'(c2), 64'(x2));
    check_eq("fl_hilo1", rh1, x1 ? e : last1);
    check_eq("fl_hilo2", rh2, x2 ? e : last2);
    if (x1) last1 = e;
    if (x2) last2 = e;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; req_op = 3'd0;
    req_reg0 = 32'd0; req_reg1 = 32'd0; req_hilo = 64'd0;
    last1 = 64'd0; last2 = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'({rdy1, rdy2}), 64'(2'b11));
    check_eq("rst_busy", 64'({busy1, busy2}), 64'(2'b00));
    check_eq("rst_valid", 64'({rv1, rv2}), 64'(2'b00));
    check_eq("rst_hilo", rh1 | rh2, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 64'd0);
    run_op(3'b101, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0000_0000_0001);
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 64'd0);
    run_op(3'b011, 32'h1234_5678, 32'h0000_0000, 64'd0);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
    run_op(3'b010, 32'h8000_0005, 32'h0000_0000, 64'd0);
    run_op(3'b110, 32'h0000_0007, 32'hFFFF_FFFD, 64'h0000_0001_0000_0000);
    run_op(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd5);
    run_op(3'b011, 32'h0000_0000, 32'h0000_0007, 64'd0);

    run_flush(3'b011, 32'hDEAD_BEEF, 32'h0000_1234, 64'd0, 10);
    run_op(3'b001, 32'd3, 32'd5, 64'd0);

    // flush together with req_valid in IDLE drops the request
    req_valid = 1'b1; flush = 1'b1; req_op = 3'b001; req_reg0 = 32'd3; req_reg1 = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check_eq("idle_flush_busy", 64'({busy1, busy2}), 64'(2'b00));
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      if (rv1 || rv2) cnt++;
      @(posedge clk); #1;
    end
    check_eq("idle_flush_resp", 64'(cnt), 64'd0);
    check_eq("idle_flush_hilo", rh1, last1);

    run_op(3'b011, 32'h0000_0010, 32'h0000_0003, 64'd0);
    run_flush(3'b000, 32'h0001_0000, 32'h0000_0300, 64'd0, 3);
    run_flush(3'b110, 32'h1234_0000, 32'h0000_0055, 64'd9, 1);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = 3'($urandom);
      if (i % 10 == 9) begin
        run_flush(op, rand_operand(), rand_operand(), {$urandom, $urandom}, $urandom_range(1, 12));
      end else begin
        run_op(op, rand_operand(), rand_operand(), {$urandom, $urandom});
      end
    end

    // reset in the middle of a divide
    issue(3'b011, 32'hFFFF_0000, 32'h0000_0013, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_ready", 64'({rdy1, rdy2}), 64'(2'b11));
    check_eq("mid_rst_hilo", rh1 | rh2, 64'd0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (rv1 || rv2) cnt++;
      @(posedge clk); #1;
    end
    check_eq("mid_rst_resp", 64'(cnt), 64'd0);
    last1 = 64'd0; last2 = 64'd0;
    run_op(3'b000, 32'h7FFF_FFFF, 32'h8000_0000, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
